// File: rtl/axi_lrsc_reservation_table.sv
// rtl/axi_lrsc_reservation_table.sv - multi-slot LR/SC reservation table (optional expiry: AXI_LRSC_TIMEOUT_EN)
module axi_lrsc_reservation_table #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int NUM_RSV        = 4,
    parameter int RSV_GRAN_LOG2  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          lr_valid_i,
    output logic                          lr_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     lr_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]       lr_id_i,
    input  logic                          sc_valid_i,
    output logic                          sc_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     sc_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]       sc_id_i,
    output logic                          sc_rsp_valid_o,
    input  logic                          sc_rsp_ready_i,
    output logic                          sc_rsp_ok_o,
    output logic [AXI_ID_WIDTH-1:0]       sc_rsp_id_o,
    input  logic                          wr_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     wr_addr_i,
    output logic [$clog2(NUM_RSV+1)-1:0]  rsv_count_o
);
    localparam int GW    = AXI_ADDR_WIDTH - RSV_GRAN_LOG2;
    localparam int PTR_W = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
    localparam int CNT_W = $clog2(NUM_RSV + 1);
    localparam int AGE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NUM_RSV-1:0]      slot_valid_q, slot_valid_d;
    logic [AXI_ID_WIDTH-1:0] slot_id_q   [NUM_RSV];
    logic [AXI_ID_WIDTH-1:0] slot_id_d   [NUM_RSV];
    logic [GW-1:0]           slot_gran_q [NUM_RSV];
    logic [GW-1:0]           slot_gran_d [NUM_RSV];
    logic [PTR_W-1:0]        vptr_q, vptr_d;
    logic                    lr_ready_q;
    logic                    rsp_valid_q, rsp_ok_q;
    logic [AXI_ID_WIDTH-1:0] rsp_id_q;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [NUM_RSV-1:0] wr_hit, sc_id_hit, expired;
    logic               sc_fire, lr_fire, sc_ok;
    logic               same_found, free_found;
    logic [PTR_W-1:0]   same_idx, free_idx, inst_idx;
    logic [GW-1:0]      wr_gran, sc_gran, lr_gran;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{lr_addr_i[RSV_GRAN_LOG2-1:0], sc_addr_i[RSV_GRAN_LOG2-1:0],
                                wr_addr_i[RSV_GRAN_LOG2-1:0]};

    assign wr_gran    = wr_addr_i[AXI_ADDR_WIDTH-1:RSV_GRAN_LOG2];
    assign sc_gran    = sc_addr_i[AXI_ADDR_WIDTH-1:RSV_GRAN_LOG2];
    assign lr_gran    = lr_addr_i[AXI_ADDR_WIDTH-1:RSV_GRAN_LOG2];
    assign sc_ready_o = !rst_i && (!rsp_valid_q || sc_rsp_ready_i);
    assign lr_ready_o = lr_ready_q;
    assign sc_fire    = sc_valid_i && sc_ready_o;
    assign lr_fire    = lr_valid_i && lr_ready_q;

`ifdef AXI_LRSC_TIMEOUT_EN
    logic [AGE_W-1:0] age_q [NUM_RSV];
    logic [AGE_W-1:0] age_d [NUM_RSV];

    always_comb begin
        for (int i = 0; i < NUM_RSV; i++) begin
            expired[i] = slot_valid_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1));
            age_d[i]   = age_q[i];
            if (slot_valid_q[i] && !expired[i])
                age_d[i] = age_q[i] + AGE_W'(1);
            if (lr_fire && (inst_idx == PTR_W'(i)))
                age_d[i] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_RSV; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RSV; i++) age_q[i] <= age_d[i];
        end
    end
`else
    logic [AGE_W-1:0] unused_age;
    assign unused_age = '0;
    assign expired    = '0;
`endif

    // Ordering inside one cycle: write clears, then SC, then LR install on top.
    always_comb begin
        sc_ok      = 1'b0;
        same_found = 1'b0;
        same_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_RSV; i++) begin
            wr_hit[i]    = wr_valid_i && slot_valid_q[i] && (slot_gran_q[i] == wr_gran);
            sc_id_hit[i] = slot_valid_q[i] && (slot_id_q[i] == sc_id_i);
            if (sc_id_hit[i] && (slot_gran_q[i] == sc_gran) && !wr_hit[i])
                sc_ok = 1'b1;
            if (slot_valid_q[i] && (slot_id_q[i] == lr_id_i)) begin
                same_found = 1'b1;
                same_idx   = PTR_W'(i);
            end
        end
        slot_valid_d = slot_valid_q & ~wr_hit & ~expired & ~(sc_fire ? sc_id_hit : '0);
        for (int i = NUM_RSV - 1; i >= 0; i--) begin
            if (!slot_valid_d[i]) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
        end
        inst_idx = same_found ? same_idx : (free_found ? free_idx : vptr_q);
        vptr_d   = vptr_q;
        if (lr_fire && !same_found && !free_found)
            vptr_d = (vptr_q == PTR_W'(NUM_RSV - 1)) ? '0 : vptr_q + PTR_W'(1);
        for (int i = 0; i < NUM_RSV; i++) begin
            slot_id_d[i]   = slot_id_q[i];
            slot_gran_d[i] = slot_gran_q[i];
            if (lr_fire && (inst_idx == PTR_W'(i))) begin
                slot_valid_d[i] = 1'b1;
                slot_id_d[i]    = lr_id_i;
                slot_gran_d[i]  = lr_gran;
            end
        end
        count_d = '0;
        for (int i = 0; i < NUM_RSV; i++)
            count_d = count_d + CNT_W'(slot_valid_d[i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_RSV; i++) begin
                slot_id_q[i]   <= '0;
                slot_gran_q[i] <= '0;
            end
            vptr_q      <= '0;
            lr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_id_q    <= '0;
            count_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < NUM_RSV; i++) begin
                slot_id_q[i]   <= slot_id_d[i];
                slot_gran_q[i] <= slot_gran_d[i];
            end
            vptr_q     <= vptr_d;
            lr_ready_q <= 1'b1;
            count_q    <= count_d;
            if (sc_ready_o) begin
                rsp_valid_q <= sc_fire;
                if (sc_fire) begin
                    rsp_ok_q <= sc_ok;
                    rsp_id_q <= sc_id_i;
                end
            end
        end
    end

    assign sc_rsp_valid_o = rsp_valid_q;
    assign sc_rsp_ok_o    = rsp_ok_q;
    assign sc_rsp_id_o    = rsp_id_q;
    assign rsv_count_o    = count_q;
endmodule
